// File: rtl/external_bus_interface_if.sv
`default_nettype none
// ============================================================================
// Module      : external_bus_interface_if
// Description : External memory bus between the bus-cycle sequencer (master)
//               and the memory subsystem (slave): address, write data,
//               request/write-enable and the read-data/ready return path.
// Revision    : 1.0 - initial release
// ============================================================================
interface external_bus_interface_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_req,
    output mem_we,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_req,
    input  mem_we,
    output mem_rdata,
    output mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/external_bus_interface.sv
`default_nettype none
// ============================================================================
// Module      : external_bus_interface
// Description : Bus-cycle sequencer between the CPU core dataflow and external
//               memory. Latches ABH/ABL, DOR and direction, runs a req/ready
//               handshake, honours RDY for reads, captures read data into a
//               stable input latch and stalls the core until retirement.
// Options     : BUS_TIMEOUT_EN - abort an access after TIMEOUT_CYCLES ACCESS
//               cycles without mem_ready (read data forced to 8'hFF).
// Revision    : 1.0 - initial release
// ============================================================================
module external_bus_interface #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic                   clk,
  input  wire logic                   nrst,
  input  wire logic [7:0]             cpu_addr_low,
  input  wire logic [7:0]             cpu_addr_high,
  input  wire logic [7:0]             cpu_data_out,
  input  wire logic                   cpu_write,
  input  wire logic                   cpu_cycle_valid,
  input  wire logic                   rdy,
  output logic [7:0]                  cpu_data_in,
  output logic                        core_stall,
  output logic                        cycle_done,
  output logic                        bus_error,
  external_bus_interface_if.master    bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [7:0]  r_cpu_data_in;
  logic        r_cycle_done;
  logic        w_accept;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_timeout_cnt;
  logic       r_bus_error;
`else
  // Parameter only matters when the timeout option is built in.
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  // Writes never wait on RDY; reads are held off while RDY is low.
  assign w_accept = cpu_cycle_valid & (cpu_write | rdy);

  // Sequencer: accept in IDLE, hold the bus frozen in ACCESS until retirement.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= ST_IDLE;
      r_mem_addr    <= 16'h0000;
      r_mem_wdata   <= 8'h00;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_cpu_data_in <= 8'h00;
      r_cycle_done  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_timeout_cnt <= 8'd0;
      r_bus_error   <= 1'b0;
`endif
    end else begin
      r_cycle_done <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_bus_error  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mem_addr    <= {cpu_addr_high, cpu_addr_low};
            r_mem_wdata   <= cpu_data_out;
            r_mem_we      <= cpu_write;
            r_mem_req     <= 1'b1;
            r_state       <= ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
            r_timeout_cnt <= 8'd0;
`endif
          end
        end
        ST_ACCESS: begin
          if (bus.mem_ready) begin
            if (!r_mem_we) begin
              r_cpu_data_in <= bus.mem_rdata;
            end
            r_mem_req    <= 1'b0;
            r_cycle_done <= 1'b1;
            r_state      <= ST_IDLE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (r_timeout_cnt == c_TIMEOUT_LAST) begin
            // Last allowed wait cycle expired: abort, poisoning read data.
            if (!r_mem_we) begin
              r_cpu_data_in <= 8'hFF;
            end
            r_mem_req    <= 1'b0;
            r_cycle_done <= 1'b1;
            r_bus_error  <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_timeout_cnt <= r_timeout_cnt + 8'd1;
          end
`endif
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Stall covers the accept cycle and every ACCESS cycle.
  assign core_stall    = (r_state == ST_ACCESS) | ((r_state == ST_IDLE) & cpu_cycle_valid);

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign cpu_data_in   = r_cpu_data_in;
  assign cycle_done    = r_cycle_done;
`ifdef BUS_TIMEOUT_EN
  assign bus_error     = r_bus_error;
`else
  assign bus_error     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_external_bus_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_external_bus_interface
// Description : Self-checking bench for external_bus_interface. Transactions
//               are described at bus-cycle level (address, data, direction,
//               wait count, RDY hold count) and the expected cycle-by-cycle
//               bus view and read latch are derived from those descriptors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_external_bus_interface;

  logic       clk;
  logic       nrst;
  logic [7:0] cpu_addr_low;
  logic [7:0] cpu_addr_high;
  logic [7:0] cpu_data_out;
  logic       cpu_write;
  logic       cpu_cycle_valid;
  logic       rdy;
  logic [7:0] cpu_data_in;
  logic       core_stall;
  logic       cycle_done;
  logic       bus_error;

  external_bus_interface_if bus_if ();

  external_bus_interface #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .cpu_addr_low    (cpu_addr_low),
    .cpu_addr_high   (cpu_addr_high),
    .cpu_data_out    (cpu_data_out),
    .cpu_write       (cpu_write),
    .cpu_cycle_valid (cpu_cycle_valid),
    .rdy             (rdy),
    .cpu_data_in     (cpu_data_in),
    .core_stall      (core_stall),
    .cycle_done      (cycle_done),
    .bus_error       (bus_error),
    .bus             (bus_if)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int c_MAX_WAIT = 3;
`else
  localparam int c_MAX_WAIT = 6;
`endif

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One complete bus cycle. Entered and left just after a rising edge, DUT idle.
  task automatic do_txn(input logic [15:0] addr, input logic [7:0] data, input logic wr,
                        input int waits, input int hold, input logic [7:0] rdata);
    cpu_addr_high    = addr[15:8];
    cpu_addr_low     = addr[7:0];
    cpu_data_out     = data;
    cpu_write        = wr;
    cpu_cycle_valid  = 1'b1;
    rdy              = (hold > 0) ? 1'b0 : 1'b1;
    bus_if.mem_ready = 1'($urandom_range(0, 1));
    if (!wr) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_req", bus_if.mem_req, 0);
        chk("hold_stall", core_stall, 1);
        @(posedge clk); #1;
        bus_if.mem_ready = 1'($urandom_range(0, 1));
        if (i == hold - 1) rdy = 1'b1;
      end
    end
    @(negedge clk);
    chk("accept_stall", core_stall, 1);
    chk("accept_req", bus_if.mem_req, 0);
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      cpu_addr_low     = 8'($urandom);
      cpu_addr_high    = 8'($urandom);
      cpu_data_out     = 8'($urandom);
      cpu_write        = 1'($urandom_range(0, 1));
      rdy              = 1'($urandom_range(0, 1));
      bus_if.mem_ready = (i == waits);
      bus_if.mem_rdata = (i == waits) ? rdata : 8'($urandom);
      @(negedge clk);
      chk("acc_req", bus_if.mem_req, 1);
      chk("acc_addr", bus_if.mem_addr, addr);
      chk("acc_we", bus_if.mem_we, wr);
      if (wr) chk("acc_wdata", bus_if.mem_wdata, data);
      chk("acc_stall", core_stall, 1);
      chk("acc_done", cycle_done, 0);
      chk("acc_rlatch", cpu_data_in, exp_data);
      @(posedge clk); #1;
    end
    if (!wr) exp_data = rdata;
    cpu_cycle_valid  = 1'b0;
    bus_if.mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("ret_done", cycle_done, 1);
    chk("ret_req", bus_if.mem_req, 0);
    chk("ret_rdata", cpu_data_in, exp_data);
    chk("ret_stall", core_stall, 0);
    chk("ret_err", bus_error, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_done", cycle_done, 0);
    chk("post_rdata", cpu_data_in, exp_data);
    @(posedge clk); #1;
  endtask

  // Reset asserted while a read waits on memory: cycle discarded silently.
  task automatic reset_mid_access();
    cpu_addr_high    = 8'h40;
    cpu_addr_low     = 8'h10;
    cpu_write        = 1'b0;
    cpu_cycle_valid  = 1'b1;
    rdy              = 1'b1;
    bus_if.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_req", bus_if.mem_req, 1);
    #2 nrst = 1'b0;
    #1;
    chk("rst_async_req", bus_if.mem_req, 0);
    chk("rst_rdata", cpu_data_in, 0);
    chk("rst_done", cycle_done, 0);
    exp_data        = 8'h00;
    cpu_cycle_valid = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_after_done", cycle_done, 0);
    chk("rst_after_req", bus_if.mem_req, 0);
    chk("rst_after_stall", core_stall, 0);
    @(posedge clk); #1;
  endtask

`ifdef BUS_TIMEOUT_EN
  // Memory never answers: abort after the 4th ACCESS cycle.
  task automatic timeout_txn(input logic wr);
    cpu_addr_high    = 8'hC0;
    cpu_addr_low     = 8'h01;
    cpu_data_out     = 8'h77;
    cpu_write        = wr;
    cpu_cycle_valid  = 1'b1;
    rdy              = 1'b1;
    bus_if.mem_ready = 1'b0;
    @(posedge clk); #1;
    cpu_cycle_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req", bus_if.mem_req, 1);
      chk("to_err_early", bus_error, 0);
      @(posedge clk); #1;
    end
    if (!wr) exp_data = 8'hFF;
    @(negedge clk);
    chk("to_err", bus_error, 1);
    chk("to_done", cycle_done, 1);
    chk("to_req_drop", bus_if.mem_req, 0);
    chk("to_rdata", cpu_data_in, exp_data);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_err_pulse", bus_error, 0);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    nrst             = 1'b0;
    cpu_addr_low     = 8'h00;
    cpu_addr_high    = 8'h00;
    cpu_data_out     = 8'h00;
    cpu_write        = 1'b0;
    cpu_cycle_valid  = 1'b0;
    rdy              = 1'b1;
    bus_if.mem_rdata = 8'h00;
    bus_if.mem_ready = 1'b0;
    exp_data         = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", bus_if.mem_addr, 16'h0000);
    chk("rst_wdata", bus_if.mem_wdata, 8'h00);
    chk("rst_req", bus_if.mem_req, 0);
    chk("rst_we", bus_if.mem_we, 0);
    chk("rst_rlatch", cpu_data_in, 8'h00);
    chk("rst_cdone", cycle_done, 0);
    chk("rst_berr", bus_error, 0);
    chk("rst_stall", core_stall, 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    do_txn(16'h1234, 8'h00, 1'b0, 0, 0, 8'hA5);
    do_txn(16'h01FD, 8'h5A, 1'b1, 3, 0, 8'h3C);
    do_txn(16'h2000, 8'h00, 1'b0, 1, 4, 8'h81);
    do_txn(16'h3001, 8'hC3, 1'b1, 0, 2, 8'h99);
    reset_mid_access();
    do_txn(16'h1234, 8'h00, 1'b0, 2, 0, 8'h6E);
`ifdef BUS_TIMEOUT_EN
    timeout_txn(1'b0);
    timeout_txn(1'b1);
    do_txn(16'hBEEF, 8'h00, 1'b0, 3, 0, 8'h42);
`else
    do_txn(16'hBEEF, 8'h00, 1'b0, 12, 0, 8'h42);
`endif

    for (int n = 0; n < 40; n++) begin
      do_txn(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, c_MAX_WAIT)), int'($urandom_range(0, 2)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/external_bus_interface.md
# external_bus_interface

Bus-cycle sequencer between the CPU core's internal dataflow and external memory. It latches the core's address bytes (ABH/ABL), write data (DOR) and cycle direction, then runs a request/ready handshake with memory. It honours the 6502-style RDY input, captures read data into a stable input latch, and stalls the core until the cycle retires. Its read latch drives the dataflow's external data-bus read input.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, number of ACCESS cycles allowed without mem_ready before abort; used only with BUS_TIMEOUT_EN; legal range 2..255.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `nrst`.
- clk  in  1  system clock; all state updates on the rising edge.
- nrst  in  1  asynchronous active-low reset.
- cpu_addr_low  in  8  address bus low byte from the ABL register.
- cpu_addr_high  in  8  address bus high byte from the ABH register.
- cpu_data_out  in  8  write data from the DOR register.
- cpu_write  in  1  1 = write cycle, 0 = read cycle.
- cpu_cycle_valid  in  1  core requests a bus cycle.
- rdy  in  1  active-high ready pin; low holds off new read cycles.
- cpu_data_in  out  8  latched read data, fed to the dataflow's external DB read input.
- core_stall  out  1  core must hold its state and request.
- cycle_done  out  1  one-cycle pulse when a cycle retires.
- bus_error  out  1  one-cycle pulse on timeout abort.
- mem_addr  out  16  {addr_high, addr_low} held for the whole access.
- mem_wdata  out  8  write data held for the whole access.
- mem_req  out  1  access request.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_rdata  in  8  read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes the access this cycle.

## Operation
- States: IDLE, ACCESS.
- Reset values: state IDLE, mem_addr 16'h0000, mem_wdata 8'h00, mem_req 0, mem_we 0, cpu_data_in 8'h00, cycle_done 0, bus_error 0, timeout counter 0.
- Transitions out of IDLE:
  - cpu_cycle_valid=1 and (cpu_write=1 or rdy=1): latch address, data and direction. Set mem_req=1 and mem_we=cpu_write. Go to ACCESS.
  - cpu_cycle_valid=1, cpu_write=0 and rdy=0: stay in IDLE. The request is not accepted.
  - Writes ignore rdy.
- ACCESS:
  - mem_addr, mem_wdata and mem_we stay frozen, whatever the cpu_* inputs do.
  - mem_ready=1: on a read, capture mem_rdata into cpu_data_in. Set mem_req=0, pulse cycle_done, return to IDLE.
  - mem_ready=0: remain in ACCESS.
- cpu_data_in changes only on a completed read or a timeout abort. It holds its value across writes and idle cycles.
- core_stall (combinational) = (state==ACCESS) | (state==IDLE & cpu_cycle_valid).
- Back-to-back operation: if cpu_cycle_valid is still high in the IDLE cycle after retirement, it is accepted as a new cycle. The core deasserts valid on the cycle_done cycle if it has no further request.
- Reset mid-ACCESS: mem_req drops asynchronously. The cycle is discarded, with no cycle_done and no data capture.

## Timing
- Latency: request sampled in IDLE at edge T; mem_req high from T.
- Memory with mem_ready=1 on its first ACCESS cycle retires at edge T+1.
- Minimum latency is 2 cycles from the valid assertion cycle to the first stall-free cycle. Each wait cycle adds 1.
- cycle_done and bus_error are registered. They are high in the cycle after the retiring edge.
- The new cpu_data_in value is visible in the same cycle as cycle_done.
- mem_ready is ignored in IDLE.

## Configuration
- BUS_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with mem_ready=0.
  - If mem_ready=0 in the TIMEOUT_CYCLES-th ACCESS cycle, the cycle aborts at that edge. Effects: cpu_data_in=8'hFF (reads only), mem_req=0, bus_error pulse, cycle_done pulse, return to IDLE.
  - mem_ready=1 in that same cycle completes normally; no error.
- BUS_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, bus_error tied 0, TIMEOUT_CYCLES unused.

## Test plan
- Read with zero wait: addr_high=8'h12, addr_low=8'h34, write=0, valid for 1 cycle, mem_ready=1 with rdata=8'hA5 -> mem_addr=16'h1234 and mem_req=1 for 1 cycle; cpu_data_in=8'hA5 with cycle_done; core_stall high for exactly 2 cycles.
- Write with 3 wait cycles: addr 16'h01FD, data 8'h5A, mem_ready low 3 cycles -> mem_we=1, mem_wdata=8'h5A stable for 4 cycles; cpu_data_in unchanged; one cycle_done pulse.
- RDY hold: rdy=0, read valid for 4 cycles -> mem_req stays 0 and core_stall=1. After rdy=1, the access starts on the next edge. A write issued with rdy=0 starts immediately.
- Input freeze: change cpu_addr_low from 8'h34 to 8'hFF during ACCESS -> mem_addr stays 16'h1234.
- Reset mid-ACCESS: nrst low during a wait -> mem_req=0 immediately, cpu_data_in=8'h00, no cycle_done; the next request after reset proceeds normally.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4): read with mem_ready held 0 -> abort after the 4th ACCESS cycle, cpu_data_in=8'hFF, bus_error and cycle_done pulse together. A repeat with mem_ready=1 in the 4th cycle completes normally.
